// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Synchronizes N raw asynchronous inputs, detects rising edges, applies a
// per-channel lockout window and latches accepted edges as pending events.
// A round-robin arbiter hands pending events, one at a time, to a single
// consumer over a valid/ready handshake. Sticky overflow flags record edges
// that arrived while the previous event of that channel was still pending.
module edge_event_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int LOCKOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in,
    input  logic           ev_ready,
    input  logic           clr_ovf,
    output logic           ev_valid,
    output logic [IDW-1:0] ev_id,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   ovf
);

    // Counter wide enough to hold LOCKOUT; at least one bit when LOCKOUT is 0.
    localparam int CW = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT);
    localparam logic [CW-1:0] LOCK_ONE  = CW'(1);
    localparam logic [CW-1:0] LOCK_ZERO = CW'(0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [N-1:0]   sync1_r;
    logic [N-1:0]   sync2_r;
    logic [N-1:0]   rise_s;
    logic [N-1:0]   accept_s;
    logic [N-1:0]   ack_vec_s;
    logic [N-1:0]   ovf_set_s;
    logic [CW-1:0]  lock_cnt_r [N];
    logic [N-1:0]   pending_r;
    logic [N-1:0]   ovf_r;
    logic [0:0]     state_r;
    logic           ev_valid_r;
    logic [IDW-1:0] ev_id_r;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] sel_s;
    logic           found_s;
    logic           ack_s;

    assign ev_valid = ev_valid_r;
    assign ev_id    = ev_id_r;
    assign pending  = pending_r;
    assign ovf      = ovf_r;

    // Two-flop synchronizer per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    // Rising edge seen between the two synchronizer stages.
    always_comb begin
        rise_s = sync1_r & ~sync2_r;
    end

    // An edge counts only when its channel is outside the lockout window.
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < N; i++) begin
            accept_s[i] = rise_s[i] & (lock_cnt_r[i] == LOCK_ZERO);
        end
    end

    // Lockout counters: reload on accept, count down to zero and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                lock_cnt_r[i] <= LOCK_ZERO;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept_s[i]) begin
                    lock_cnt_r[i] <= LOCK_LOAD;
                end else if (lock_cnt_r[i] != LOCK_ZERO) begin
                    lock_cnt_r[i] <= lock_cnt_r[i] - LOCK_ONE;
                end else begin
                    lock_cnt_r[i] <= lock_cnt_r[i];
                end
            end
        end
    end

    // Handshake completes when an offered event meets ready.
    always_comb begin
        ack_s = (state_r == ST_OFFER) & ev_valid_r & ev_ready;
    end

    // One-hot of the channel being acknowledged this cycle.
    always_comb begin
        ack_vec_s = '0;
        if (ack_s) begin
            ack_vec_s[ev_id_r] = 1'b1;
        end else begin
            ack_vec_s = '0;
        end
    end

    // Overflow: a new edge on a still-pending channel not being acked now.
    always_comb begin
        ovf_set_s = accept_s & pending_r & ~ack_vec_s;
    end

    // Pending flags: ack clears, accepted edge sets (set wins over the ack).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~ack_vec_s) | accept_s;
        end
    end

    // Sticky overflow flags; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= '0;
        end else if (clr_ovf) begin
            ovf_r <= ovf_set_s;
        end else begin
            ovf_r <= ovf_r | ovf_set_s;
        end
    end

    // Round-robin pick: first pending channel after the last granted one.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found_s && pending_r[(int'(ptr_r) + k) % N]) begin
                found_s = 1'b1;
                sel_s   = IDW'((int'(ptr_r) + k) % N);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Offer FSM: latch a winner in IDLE, hold it in OFFER until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ev_valid_r <= 1'b0;
            ev_id_r    <= '0;
            ptr_r      <= IDW'(N - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        ev_id_r    <= sel_s;
                        ev_valid_r <= 1'b1;
                        state_r    <= ST_OFFER;
                    end else begin
                        ev_valid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    if (ev_ready) begin
                        ptr_r      <= ev_id_r;
                        ev_valid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        ev_valid_r <= 1'b1;
                        state_r    <= ST_OFFER;
                    end
                end
                default: begin
                    ev_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N=4, LOCKOUT=16).
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_s;
    logic       ev_ready_s;
    logic       clr_ovf_s;
    logic       ev_valid_s;
    logic [1:0] ev_id_s;
    logic [3:0] pending_s;
    logic [3:0] ovf_s;

    int total_cnt;
    int bad_cnt;
    int ev_cnt;

    edge_event_arbiter #(.N(4), .IDW(2), .LOCKOUT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_s),
        .ev_ready (ev_ready_s),
        .clr_ovf  (clr_ovf_s),
        .ev_valid (ev_valid_s),
        .ev_id    (ev_id_s),
        .pending  (pending_s),
        .ovf      (ovf_s)
    );

    // 100 MHz-style free running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_s       = 4'b0000;
        ev_ready_s = 1'b0;
        clr_ovf_s  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        do_reset();
        chk("rst_valid",   32'(ev_valid_s), 32'd0);
        chk("rst_pending", 32'(pending_s),  32'd0);
        chk("rst_ovf",     32'(ovf_s),      32'd0);

        // 1: single press on ch2
        ev_ready_s = 1'b1;
        in_s = 4'b0100;
        tick(1);
        chk("t1_pend_e1", 32'(pending_s), 32'h0);
        tick(1);
        chk("t1_pend_e2",  32'(pending_s),  32'h4);
        chk("t1_valid_e2", 32'(ev_valid_s), 32'd0);
        tick(1);
        chk("t1_valid_e3", 32'(ev_valid_s), 32'd1);
        chk("t1_id_e3",    32'(ev_id_s),    32'd2);
        in_s = 4'b0000;
        tick(1);
        chk("t1_valid_e4", 32'(ev_valid_s), 32'd0);
        chk("t1_pend_e4",  32'(pending_s),  32'h0);

        // 2: all four rise together, then ch1 and ch3
        do_reset();
        ev_ready_s = 1'b1;
        in_s = 4'b1111;
        tick(2);
        chk("t2_pend_all", 32'(pending_s), 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("t2_valid", 32'(ev_valid_s), 32'd1);
            chk("t2_id",    32'(ev_id_s),    32'(k));
            tick(1);
            chk("t2_gap",   32'(ev_valid_s), 32'd0);
        end
        chk("t2_pend_empty", 32'(pending_s), 32'h0);
        in_s = 4'b0000;
        tick(20);
        in_s = 4'b1010;
        tick(3);
        chk("t2_rr_first",  32'(ev_id_s),    32'd1);
        chk("t2_rr_valid1", 32'(ev_valid_s), 32'd1);
        tick(2);
        chk("t2_rr_second", 32'(ev_id_s),    32'd3);
        chk("t2_rr_valid2", 32'(ev_valid_s), 32'd1);
        in_s = 4'b0000;
        tick(20);

        // 3: bouncing ch1 toggling every 3 cycles
        ev_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) in_s = 4'b0010;
            else if (i % 6 == 3) in_s = 4'b0000;
            else in_s = in_s;
            tick(1);
            if (ev_valid_s) ev_cnt++;
            if (i == 18) chk("t3_one_in_window", 32'(ev_cnt), 32'd1);
            if (i == 20) begin
                chk("t3_relock_valid", 32'(ev_valid_s), 32'd1);
                chk("t3_relock_id",    32'(ev_id_s),    32'd1);
            end
        end
        chk("t3_total_events", 32'(ev_cnt), 32'd2);
        chk("t3_no_ovf",       32'(ovf_s),  32'h0);
        in_s = 4'b0000;
        tick(20);

        // 4: overflow on ch0 while stalled, then clear
        ev_ready_s = 1'b0;
        in_s = 4'b0001;
        tick(3);
        chk("t4_offer_valid", 32'(ev_valid_s), 32'd1);
        chk("t4_offer_id",    32'(ev_id_s),    32'd0);
        in_s = 4'b0000;
        tick(20);
        chk("t4_hold_valid", 32'(ev_valid_s), 32'd1);
        chk("t4_hold_id",    32'(ev_id_s),    32'd0);
        in_s = 4'b0001;
        tick(2);
        chk("t4_ovf_set", 32'(ovf_s),     32'h1);
        chk("t4_pend",    32'(pending_s), 32'h1);
        ev_ready_s = 1'b1;
        tick(1);
        chk("t4_ack_valid", 32'(ev_valid_s), 32'd0);
        chk("t4_ack_pend",  32'(pending_s),  32'h0);
        chk("t4_ovf_stick", 32'(ovf_s),      32'h1);
        ev_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (ev_valid_s) ev_cnt++;
        end
        chk("t4_single_event", 32'(ev_cnt), 32'd0);
        in_s = 4'b0000;
        clr_ovf_s = 1'b1;
        tick(1);
        clr_ovf_s = 1'b0;
        chk("t4_ovf_clr", 32'(ovf_s), 32'h0);
        tick(20);

        // 5: ch2 rise accepted in the same cycle as the ch2 ack
        ev_ready_s = 1'b0;
        in_s = 4'b0100;
        tick(3);
        chk("t5_offer_id", 32'(ev_id_s), 32'd2);
        in_s = 4'b0000;
        tick(20);
        in_s = 4'b0100;
        tick(1);
        ev_ready_s = 1'b1;
        tick(1);
        chk("t5_pend_kept", 32'(pending_s),  32'h4);
        chk("t5_no_ovf",    32'(ovf_s),      32'h0);
        chk("t5_idle",      32'(ev_valid_s), 32'd0);
        tick(1);
        chk("t5_reoffer_valid", 32'(ev_valid_s), 32'd1);
        chk("t5_reoffer_id",    32'(ev_id_s),    32'd2);
        tick(1);
        chk("t5_final_pend", 32'(pending_s), 32'h0);
        ev_ready_s = 1'b0;
        in_s = 4'b0000;
        tick(20);

        // 6: reset while offering with an overflow recorded
        in_s = 4'b1010;
        tick(3);
        chk("t6_offer_id", 32'(ev_id_s), 32'd3);
        in_s = 4'b0000;
        tick(20);
        in_s = 4'b1000;
        tick(2);
        chk("t6_ovf_pre", 32'(ovf_s),     32'h8);
        chk("t6_pend_pre", 32'(pending_s), 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ev_valid_s), 32'd0);
        chk("t6_rst_pend",  32'(pending_s),  32'h0);
        chk("t6_rst_ovf",   32'(ovf_s),      32'h0);
        in_s = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        ev_ready_s = 1'b1;
        in_s = 4'b1001;
        tick(3);
        chk("t6_first_grant", 32'(ev_id_s),    32'd0);
        chk("t6_first_valid", 32'(ev_valid_s), 32'd1);
        tick(2);
        chk("t6_second_grant", 32'(ev_id_s), 32'd3);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
